// File: rtl/irq_pkg.sv
// Shared types and register map for the external interrupt arbiter.
//   irq_state_e : arbiter FSM state encoding
//   IRQ_*       : config register addresses
package irq_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      REQ    = 2'd1,
      ACTIVE = 2'd2
   } irq_state_e;

   localparam logic [3:0] IRQ_PRIO_BASE = 4'h0;
   localparam logic [3:0] IRQ_ENABLE    = 4'h8;
   localparam logic [3:0] IRQ_THRESH    = 4'h9;
   localparam logic [3:0] IRQ_CLAIM     = 4'hA;
   localparam logic [3:0] IRQ_PENDING   = 4'hB;

endpackage

// File: rtl/irq_prio_tree.sv
// Combinational max-priority finder.
//   valid    : per-source eligibility
//   prio     : per-source priority
//   win_id   : index+1 of the highest-priority valid source, 0 when none
//   win_prio : priority of the winner, 0 when none
// Ties resolve to the lowest index because a later source must be strictly
// higher to displace the current best.
module irq_prio_tree
   import irq_pkg::*;
#(
   parameter int N_SRC  = 8,
   parameter int PRIO_W = 3
) (
   input  logic [N_SRC-1:0]             valid,
   input  logic [N_SRC-1:0][PRIO_W-1:0] prio,
   output logic [3:0]                   win_id,
   output logic [PRIO_W-1:0]            win_prio
);

   always_comb begin
      win_id   = '0;
      win_prio = '0;
      for (int i = 0; i < N_SRC; i++) begin
         if (valid[i] && ((win_id == 4'd0) || (prio[i] > win_prio))) begin
            win_id   = 4'(i + 1);
            win_prio = prio[i];
         end
      end
   end

endmodule

// File: rtl/irq_arbiter.sv
// Machine-mode external interrupt arbiter.
//   clk, rst     : clock, synchronous active-high reset
//   src_irq      : rising-edge triggered source requests
//   trap_taken   : core entered the external-interrupt trap (claim)
//   mret         : core retired MRET (complete)
//   cfg_we/addr/wdata/rdata : register port, rdata combinational
//   interrupt    : registered request to the exception unit
//   claim_id     : registered id of the source in service, 0 when none
//
// state  | meaning
// IDLE   | no eligible source, nothing in service
// REQ    | interrupt raised, waiting for the core to take the trap
// ACTIVE | a source is claimed, waiting for MRET
module irq_arbiter
   import irq_pkg::*;
#(
   parameter int N_SRC  = 8,
   parameter int PRIO_W = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N_SRC-1:0]  src_irq,
   input  logic              trap_taken,
   input  logic              mret,
   input  logic              cfg_we,
   input  logic [3:0]        cfg_addr,
   input  logic [31:0]       cfg_wdata,
   output logic [31:0]       cfg_rdata,
   output logic              interrupt,
   output logic [3:0]        claim_id
);

   logic [N_SRC-1:0]             src_q;
   logic [N_SRC-1:0]             pending;
   logic [N_SRC-1:0]             enable;
   logic [N_SRC-1:0][PRIO_W-1:0] prio;
   logic [PRIO_W-1:0]            thresh;
   logic [N_SRC-1:0]             eligible;
   logic [N_SRC-1:0]             src_edge;
   logic [N_SRC-1:0]             claim_mask;
   logic [3:0]                   win_id;
   logic [PRIO_W-1:0]            unused_win_prio;
   logic                         unused_wdata;
   logic                         claim_fire;
   irq_state_e                   state, state_nxt;

   assign src_edge     = src_irq & ~src_q;
   assign unused_wdata = ^cfg_wdata[31:N_SRC];

   always_comb begin
      eligible   = '0;
      claim_mask = '0;
      for (int i = 0; i < N_SRC; i++) begin
         eligible[i]   = pending[i] & enable[i] & (prio[i] > thresh);
         claim_mask[i] = claim_fire & (win_id == 4'(i + 1));
      end
   end

   irq_prio_tree #(
      .N_SRC  (N_SRC),
      .PRIO_W (PRIO_W)
   ) u_prio_tree (
      .valid    (eligible),
      .prio     (prio),
      .win_id   (win_id),
      .win_prio (unused_win_prio)
   );

   always_comb begin
      state_nxt  = state;
      claim_fire = 1'b0;
      case (state)
         IDLE: begin
            if (win_id != 4'd0) state_nxt = REQ;
         end
         REQ: begin
            // Losing the winner takes precedence: a trap with nothing
            // eligible has nothing to claim.
            if (win_id == 4'd0) begin
               state_nxt = IDLE;
            end else if (trap_taken) begin
               state_nxt  = ACTIVE;
               claim_fire = 1'b1;
            end
         end
         ACTIVE: begin
            if (mret) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         interrupt <= 1'b0;
         claim_id  <= '0;
         src_q     <= '0;
         pending   <= '0;
         enable    <= '0;
         prio      <= '0;
         thresh    <= '0;
      end else begin
         state     <= state_nxt;
         interrupt <= (state_nxt == REQ);
         src_q     <= src_irq;
         // Edge is OR'd in after the claim clear so a same-cycle edge wins.
         pending   <= (pending & ~claim_mask) | src_edge;
         if (claim_fire) begin
            claim_id <= win_id;
         end else if ((state == ACTIVE) && mret) begin
            claim_id <= '0;
         end
         if (cfg_we) begin
            case (cfg_addr)
               IRQ_ENABLE: enable <= cfg_wdata[N_SRC-1:0];
               IRQ_THRESH: thresh <= cfg_wdata[PRIO_W-1:0];
               default: begin
                  for (int i = 0; i < N_SRC; i++) begin
                     if ((cfg_addr == IRQ_PRIO_BASE + 4'(i)) && (cfg_addr < IRQ_ENABLE))
                        prio[i] <= cfg_wdata[PRIO_W-1:0];
                  end
               end
            endcase
         end
      end
   end

   always_comb begin
      cfg_rdata = '0;
      case (cfg_addr)
         IRQ_ENABLE:  cfg_rdata[N_SRC-1:0]  = enable;
         IRQ_THRESH:  cfg_rdata[PRIO_W-1:0] = thresh;
         IRQ_CLAIM:   cfg_rdata[3:0]        = claim_id;
         IRQ_PENDING: cfg_rdata[N_SRC-1:0]  = pending;
         default: begin
            for (int i = 0; i < N_SRC; i++) begin
               if ((cfg_addr == IRQ_PRIO_BASE + 4'(i)) && (cfg_addr < IRQ_ENABLE))
                  cfg_rdata[PRIO_W-1:0] = prio[i];
            end
         end
      endcase
   end

endmodule

// File: tb/tb_irq_arbiter.sv
// Self-checking bench for irq_arbiter: directed scenarios with literal
// expectations plus a randomized run, all outputs compared every cycle
// against a behavioural model.
module tb_irq_arbiter;

   localparam int N_SRC  = 8;
   localparam int PRIO_W = 3;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [N_SRC-1:0]  src_irq = '0;
   logic              trap_taken = 1'b0;
   logic              mret = 1'b0;
   logic              cfg_we = 1'b0;
   logic [3:0]        cfg_addr = '0;
   logic [31:0]       cfg_wdata = '0;
   logic [31:0]       cfg_rdata;
   logic              interrupt;
   logic [3:0]        claim_id;

   always #5 clk = ~clk;

   irq_arbiter #(.N_SRC(N_SRC), .PRIO_W(PRIO_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .src_irq    (src_irq),
      .trap_taken (trap_taken),
      .mret       (mret),
      .cfg_we     (cfg_we),
      .cfg_addr   (cfg_addr),
      .cfg_wdata  (cfg_wdata),
      .cfg_rdata  (cfg_rdata),
      .interrupt  (interrupt),
      .claim_id   (claim_id)
   );

   int tests = 0;
   int fails = 0;
   bit chk_en = 0;

   // Behavioural model: register contents, the source in service (0 = none)
   // and whether the request line is up.
   int m_prio[N_SRC];
   bit m_en[N_SRC];
   bit m_pend[N_SRC];
   bit m_prev[N_SRC];
   int m_thresh;
   int m_claim;
   bit m_irq;

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int m_winner();
      int best = 0;
      int best_p = 0;
      for (int i = 0; i < N_SRC; i++)
         if (m_pend[i] && m_en[i] && m_prio[i] > m_thresh && m_prio[i] > best_p) begin
            best_p = m_prio[i];
            best   = i + 1;
         end
      return best;
   endfunction

   function automatic logic [31:0] m_rdata(int a);
      logic [31:0] r = 0;
      if (a < N_SRC) r = m_prio[a];
      else if (a == 8)  for (int i = 0; i < N_SRC; i++) r[i] = m_en[i];
      else if (a == 9)  r = m_thresh;
      else if (a == 10) r = m_claim;
      else if (a == 11) for (int i = 0; i < N_SRC; i++) r[i] = m_pend[i];
      return r;
   endfunction

   // Advance the model by one clock edge using the inputs the DUT sees.
   task automatic model_step();
      int  w;
      bit  taken;
      bit  busy;
      if (rst) begin
         for (int i = 0; i < N_SRC; i++) begin
            m_prio[i] = 0; m_en[i] = 0; m_pend[i] = 0; m_prev[i] = 0;
         end
         m_thresh = 0; m_claim = 0; m_irq = 0;
         return;
      end
      w     = m_winner();
      busy  = (m_claim != 0);
      taken = !busy && m_irq && trap_taken && (w != 0);
      for (int i = 0; i < N_SRC; i++) begin
         if (taken && w == i + 1) m_pend[i] = 0;
         if (src_irq[i] && !m_prev[i]) m_pend[i] = 1;
         m_prev[i] = src_irq[i];
      end
      if (taken) m_claim = w;
      else if (busy && mret) m_claim = 0;
      // Request rises one cycle after a winner appears; it drops on claim
      // and stays down for the cycle in which MRET completes.
      m_irq = !busy && (w != 0) && !taken;
      if (cfg_we) begin
         if (cfg_addr < N_SRC) m_prio[cfg_addr] = cfg_wdata % (1 << PRIO_W);
         else if (cfg_addr == 8) for (int i = 0; i < N_SRC; i++) m_en[i] = cfg_wdata[i];
         else if (cfg_addr == 9) m_thresh = cfg_wdata % (1 << PRIO_W);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("interrupt", {31'd0, interrupt}, {31'd0, m_irq});
         check("claim_id", {28'd0, claim_id}, m_claim);
         check("cfg_rdata", cfg_rdata, m_rdata(int'(cfg_addr)));
      end
   end

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
      #2;
      trap_taken = 1'b0;
      mret       = 1'b0;
      cfg_we     = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1; src_irq = '0;
      tick();
      rst = 1'b0;
   endtask

   task automatic cfg_write(logic [3:0] a, logic [31:0] d);
      cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
      tick();
   endtask

   task automatic wait_irq(string name);
      int n = 0;
      while (!interrupt && n < 20) begin
         tick();
         n++;
      end
      check(name, {31'd0, interrupt}, 32'd1);
   endtask

   task automatic service(int exp_id);
      wait_irq("svc_irq");
      trap_taken = 1'b1;
      tick();
      check("svc_claim", {28'd0, claim_id}, exp_id);
      check("svc_irq_low", {31'd0, interrupt}, 32'd0);
      tick();
      mret = 1'b1;
      tick();
      check("svc_done", {28'd0, claim_id}, 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      model_step();
      do_reset();
      tick();
      chk_en = 1;
      check("rst_irq", {31'd0, interrupt}, 32'd0);
      check("rst_claim", {28'd0, claim_id}, 32'd0);

      // Single source latency: edge at n, interrupt at n+2.
      cfg_write(4'h2, 3);
      cfg_write(4'h8, 32'h04);
      src_irq[2] = 1'b1;
      tick();
      src_irq[2] = 1'b0;
      check("lat_n1_irq", {31'd0, interrupt}, 32'd0);
      check("lat_n1_model", {31'd0, m_pend[2]}, 32'd1);
      tick();
      check("lat_n2_irq", {31'd0, interrupt}, 32'd1);
      tick(); tick();
      trap_taken = 1'b1;
      tick();
      check("claim_id3", {28'd0, claim_id}, 32'd3);
      check("claim_irq0", {31'd0, interrupt}, 32'd0);
      repeat (3) tick();
      mret = 1'b1;
      tick();
      check("mret_claim0", {28'd0, claim_id}, 32'd0);

      // Priority ordering with a tie resolved to the lowest index.
      do_reset();
      cfg_write(4'h1, 4); cfg_write(4'h5, 4); cfg_write(4'h3, 6);
      cfg_write(4'h8, 32'hFF);
      src_irq = 8'b0010_1010;
      tick();
      src_irq = '0;
      service(4);
      service(2);
      service(6);

      // Threshold masking and release.
      do_reset();
      cfg_write(4'h9, 5); cfg_write(4'h0, 5); cfg_write(4'h8, 32'h01);
      src_irq[0] = 1'b1;
      tick();
      src_irq[0] = 1'b0;
      repeat (4) tick();
      check("thresh_mask", {31'd0, interrupt}, 32'd0);
      cfg_write(4'h9, 4);
      check("thresh_c1", {31'd0, interrupt}, 32'd0);
      tick();
      check("thresh_c2", {31'd0, interrupt}, 32'd1);

      // Disable while requesting.
      do_reset();
      cfg_write(4'h4, 2); cfg_write(4'h8, 32'h10);
      src_irq[4] = 1'b1;
      tick();
      src_irq[4] = 1'b0;
      wait_irq("dis_req");
      cfg_write(4'h8, 32'h00);
      check("dis_c1", {31'd0, interrupt}, 32'd1);
      tick();
      check("dis_c2", {31'd0, interrupt}, 32'd0);
      cfg_addr = 4'hB;
      #1;
      check("dis_pend", cfg_rdata, 32'h10);
      cfg_write(4'h8, 32'h10);
      tick();
      check("reen_irq", {31'd0, interrupt}, 32'd1);

      // Edge and claim on the same source in the same cycle.
      do_reset();
      cfg_write(4'h6, 5); cfg_write(4'h8, 32'h40);
      src_irq[6] = 1'b1;
      tick();
      src_irq[6] = 1'b0;
      wait_irq("same_req");
      src_irq[6] = 1'b1;
      trap_taken = 1'b1;
      tick();
      src_irq[6] = 1'b0;
      check("same_claim", {28'd0, claim_id}, 32'd7);
      cfg_addr = 4'hB;
      #1;
      check("same_pend", cfg_rdata, 32'h40);
      mret = 1'b1;
      tick();
      check("same_k1", {31'd0, interrupt}, 32'd0);
      tick();
      check("same_k2", {31'd0, interrupt}, 32'd1);

      // Reset while ACTIVE with more sources pending.
      trap_taken = 1'b1;
      src_irq[5] = 1'b1;
      tick();
      src_irq[5] = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mid_rst_irq", {31'd0, interrupt}, 32'd0);
      check("mid_rst_claim", {28'd0, claim_id}, 32'd0);
      cfg_addr = 4'h8; #1; check("mid_rst_en", cfg_rdata, 32'd0);
      cfg_addr = 4'hA; #1; check("mid_rst_clm", cfg_rdata, 32'd0);
      cfg_addr = 4'hB; #1; check("mid_rst_pend", cfg_rdata, 32'd0);
      mret = 1'b1;
      tick();
      check("post_rst_mret", {28'd0, claim_id}, 32'd0);

      // Randomized traffic.
      for (int c = 0; c < 4000; c++) begin
         rst        = ($urandom_range(0, 399) == 0);
         src_irq    = src_irq ^ N_SRC'($urandom & $urandom);
         trap_taken = ($urandom_range(0, 2) == 0);
         mret       = ($urandom_range(0, 3) == 0);
         cfg_addr   = 4'($urandom_range(0, 15));
         cfg_we     = ($urandom_range(0, 5) == 0);
         cfg_wdata  = $urandom;
         if (cfg_we && cfg_addr == 4'h9) cfg_wdata = $urandom_range(0, 3);
         if (cfg_we && cfg_addr == 4'h8) cfg_wdata = $urandom | 32'h0F;
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
